// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron spike path.
// Holds the ISI measurement state encoding and the default widths that the
// neuron readout and the spike decoder agree on.
package lif_pkg;

    // ISI measurement state: no reference spike yet, or timing since the last one.
    typedef enum logic {
        WAIT_FIRST = 1'b0,
        MEASURE    = 1'b1
    } isi_state_e;

    localparam int unsigned LIF_WINDOW    = 256;
    localparam int unsigned LIF_WIN_W     = 8;
    localparam int unsigned LIF_CNT_W     = 8;
    localparam int unsigned LIF_ISI_W     = 8;
    localparam int unsigned LIF_BURST_ISI = 4;

endpackage : lif_pkg

// File: rtl/lif_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk   in  1      rising-edge clock
//   rst   in  1      synchronous active-high reset, count -> 0
//   clr   in  1      restart the count; with inc set the count restarts at 1
//   inc   in  1      increment, holding at all-ones instead of wrapping
//   count out WIDTH  current count
module lif_sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            // Clear plus increment means "this cycle is the first of a new count".
            count_d = WIDTH'(inc);
        end else if (inc && count_q != MAX) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: flops use non-blocking assignments so all state updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : lif_sat_counter

// File: rtl/lif_spike_decoder.sv
// Receive side of the LIF neuron spike output.
// Converts the raw spike train into a windowed firing-rate count (valid/ready,
// one-deep holding register) and an inter-spike interval per spike, with a
// burst pulse on short intervals.
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   ena        in   1      0 freezes all measurement state; handshake keeps running
//   spike_in   in   1      neuron spike, a 0->1 transition is one spike
//   rate_ready in   1      consumer takes rate_out this cycle
//   rate_out   out  CNT_W  spike count of the last completed window
//   rate_valid out  1      rate_out holds unconsumed data
//   isi_out    out  ISI_W  cycles between the last two spikes (saturating)
//   isi_valid  out  1      single-cycle pulse when isi_out updates
//   burst      out  1      pulse with isi_valid when isi_out < BURST_ISI
//   overrun    out  1      sticky: a window result replaced an unconsumed one
module lif_spike_decoder
    import lif_pkg::*;
#(
    parameter int unsigned WINDOW    = LIF_WINDOW,
    parameter int unsigned WIN_W     = LIF_WIN_W,
    parameter int unsigned CNT_W     = LIF_CNT_W,
    parameter int unsigned ISI_W     = LIF_ISI_W,
    parameter int unsigned BURST_ISI = LIF_BURST_ISI
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             spike_in,
    input  logic             rate_ready,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_valid,
    output logic [ISI_W-1:0] isi_out,
    output logic             isi_valid,
    output logic             burst,
    output logic             overrun
);

    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [ISI_W:0]   BURST_LIM = (ISI_W + 1)'(BURST_ISI);

    logic             spike_prev_q, spike_prev_d;
    logic [WIN_W-1:0] win_cnt_q,    win_cnt_d;
    isi_state_e       state_q,      state_d;
    logic [CNT_W-1:0] rate_out_q,   rate_out_d;
    logic             rate_valid_q, rate_valid_d;
    logic [ISI_W-1:0] isi_out_q,    isi_out_d;
    logic             isi_valid_q,  isi_valid_d;
    logic             burst_q,      burst_d;
    logic             overrun_q,    overrun_d;

    logic             spike_edge;
    logic             terminal;
    logic [CNT_W-1:0] spk_cnt;
    logic [ISI_W-1:0] isi_cnt;
    logic [CNT_W-1:0] rate_result;
    logic             isi_report;

    // Edges only exist on enabled cycles; spike_prev is frozen otherwise.
    assign spike_edge = ena && spike_in && !spike_prev_q;
    assign terminal   = ena && (win_cnt_q == WIN_LAST);
    assign isi_report = spike_edge && (state_q == MEASURE);

    // A spike on the terminal cycle is folded into the ending window's result,
    // and the counter clears rather than carrying it into the next window.
    assign rate_result = (spike_edge && spk_cnt != '1) ? spk_cnt + 1'b1 : spk_cnt;

    lif_sat_counter #(.WIDTH(CNT_W)) u_spk_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (terminal),
        .inc   (spike_edge && !terminal),
        .count (spk_cnt)
    );

    // Every edge restarts the interval at 1; between edges it only runs once a
    // reference spike has been seen.
    lif_sat_counter #(.WIDTH(ISI_W)) u_isi_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (spike_edge),
        .inc   (spike_edge || (ena && state_q == MEASURE)),
        .count (isi_cnt)
    );

    always_comb begin
        spike_prev_d = spike_prev_q;
        win_cnt_d    = win_cnt_q;
        state_d      = state_q;
        rate_out_d   = rate_out_q;
        rate_valid_d = rate_valid_q;
        overrun_d    = overrun_q;
        isi_out_d    = isi_out_q;
        isi_valid_d  = 1'b0;
        burst_d      = 1'b0;

        if (ena) begin
            spike_prev_d = spike_in;
            win_cnt_d    = terminal ? '0 : win_cnt_q + 1'b1;
        end

        // Holding register: a new result always wins; it only counts as an
        // overrun if the old one was neither consumed before nor on this edge.
        if (terminal) begin
            rate_out_d   = rate_result;
            rate_valid_d = 1'b1;
            if (rate_valid_q && !rate_ready) begin
                overrun_d = 1'b1;
            end
        end else if (rate_valid_q && rate_ready) begin
            rate_valid_d = 1'b0;
        end

        if (spike_edge) begin
            state_d = MEASURE;
        end
        if (isi_report) begin
            isi_out_d   = isi_cnt;
            isi_valid_d = 1'b1;
            burst_d     = ({1'b0, isi_cnt} < BURST_LIM);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spike_prev_q <= 1'b0;
            win_cnt_q    <= '0;
            state_q      <= WAIT_FIRST;
            rate_out_q   <= '0;
            rate_valid_q <= 1'b0;
            isi_out_q    <= '0;
            isi_valid_q  <= 1'b0;
            burst_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            spike_prev_q <= spike_prev_d;
            win_cnt_q    <= win_cnt_d;
            state_q      <= state_d;
            rate_out_q   <= rate_out_d;
            rate_valid_q <= rate_valid_d;
            isi_out_q    <= isi_out_d;
            isi_valid_q  <= isi_valid_d;
            burst_q      <= burst_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rate_out   = rate_out_q;
    assign rate_valid = rate_valid_q;
    assign isi_out    = isi_out_q;
    assign isi_valid  = isi_valid_q;
    assign burst      = burst_q;
    assign overrun    = overrun_q;

endmodule : lif_spike_decoder

// File: tb/tb_lif_spike_decoder.sv
// Self-checking bench for lif_spike_decoder with a 16-cycle window.
// A timestamp-based reference model predicts every output on every cycle;
// a vector table and directed sequences add hand-derived expectations.
module tb_lif_spike_decoder;

    localparam int WINDOW    = 16;
    localparam int WIN_W     = 4;
    localparam int CNT_W     = 8;
    localparam int ISI_W     = 8;
    localparam int BURST_ISI = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;
    localparam int ISI_MAX   = (1 << ISI_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ena = 1'b0;
    logic             spike_in = 1'b0;
    logic             rate_ready = 1'b0;
    logic [CNT_W-1:0] rate_out;
    logic             rate_valid;
    logic [ISI_W-1:0] isi_out;
    logic             isi_valid;
    logic             burst;
    logic             overrun;

    int n_checks = 0;
    int n_errors = 0;

    lif_spike_decoder #(
        .WINDOW    (WINDOW),
        .WIN_W     (WIN_W),
        .CNT_W     (CNT_W),
        .ISI_W     (ISI_W),
        .BURST_ISI (BURST_ISI)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .spike_in   (spike_in),
        .rate_ready (rate_ready),
        .rate_out   (rate_out),
        .rate_valid (rate_valid),
        .isi_out    (isi_out),
        .isi_valid  (isi_valid),
        .burst      (burst),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: counts enabled cycles as a timestamp and derives the
    // interval and window membership from timestamps.
    bit m_prev;
    int m_t;
    bit m_have_last;
    int m_last_t;
    int m_win_spikes;
    int exp_rate_out, exp_isi_out;
    bit exp_rate_valid, exp_isi_valid, exp_burst, exp_overrun;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit e, load;
        int val, isi;
        if (rst) begin
            m_prev = 0; m_t = 0; m_have_last = 0; m_last_t = 0; m_win_spikes = 0;
            exp_rate_out = 0; exp_isi_out = 0;
            exp_rate_valid = 0; exp_isi_valid = 0; exp_burst = 0; exp_overrun = 0;
        end else begin
            e = ena && spike_in && !m_prev;
            load = 0;
            val = 0;
            exp_isi_valid = 0;
            exp_burst = 0;
            if (ena) begin
                if (e) begin
                    if (m_have_last) begin
                        isi = m_t - m_last_t;
                        if (isi > ISI_MAX) isi = ISI_MAX;
                        exp_isi_out = isi;
                        exp_isi_valid = 1;
                        exp_burst = (isi < BURST_ISI);
                    end
                    m_have_last = 1;
                    m_last_t = m_t;
                    m_win_spikes++;
                end
                if (m_t % WINDOW == WINDOW - 1) begin
                    load = 1;
                    val = (m_win_spikes > CNT_MAX) ? CNT_MAX : m_win_spikes;
                    m_win_spikes = 0;
                end
                m_t++;
                m_prev = spike_in;
            end
            if (load) begin
                if (exp_rate_valid && !rate_ready) exp_overrun = 1;
                exp_rate_out = val;
                exp_rate_valid = 1;
            end else if (exp_rate_valid && rate_ready) begin
                exp_rate_valid = 0;
            end
        end
    endtask

    // One clock: update the model at the edge, compare every output 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_rate_out",   int'(rate_out),   exp_rate_out);
        check("model_rate_valid", int'(rate_valid), int'(exp_rate_valid));
        check("model_isi_out",    int'(isi_out),    exp_isi_out);
        check("model_isi_valid",  int'(isi_valid),  int'(exp_isi_valid));
        check("model_burst",      int'(burst),      int'(exp_burst));
        check("model_overrun",    int'(overrun),    int'(exp_overrun));
    endtask

    task automatic step(input logic s);
        spike_in = s;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ena = 1'b1;
        spike_in = 1'b1;
        tick();
        spike_in = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic rst;
        logic ena;
        logic spike;
        logic iv;
        logic bst;
        int   isi;
    } vec_t;

    vec_t vecs[15];
    int   got_isi[$];
    bit   got_burst[$];
    int   exp_isi_seq[3]   = '{3, 27, 255};
    bit   exp_burst_seq[3] = '{1'b1, 1'b0, 1'b0};

    initial begin
        // rst ena spike | isi_valid burst isi_out
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4};

        // Reset with spikes driven: everything idle.
        rate_ready = 1'b1;
        do_reset();
        check("reset_rate_valid", int'(rate_valid), 0);
        check("reset_isi_valid",  int'(isi_valid),  0);
        check("reset_overrun",    int'(overrun),    0);
        check("reset_rate_out",   int'(rate_out),   0);

        // Vector table: first spike silent, short ISIs, ena freeze.
        for (int i = 0; i < 15; i++) begin
            rst = vecs[i].rst;
            ena = vecs[i].ena;
            spike_in = vecs[i].spike;
            tick();
            check($sformatf("vec%0d_isi_valid", i), int'(isi_valid), int'(vecs[i].iv));
            check($sformatf("vec%0d_burst", i),     int'(burst),     int'(vecs[i].bst));
            check($sformatf("vec%0d_isi_out", i),   int'(isi_out),   vecs[i].isi);
        end
        rst = 1'b0;

        // Rate: 5 spikes with period 3 in the first window.
        do_reset();
        rate_ready = 1'b1;
        for (int t = 0; t < WINDOW; t++) begin
            step((t % 3 == 0) && (t <= 12));
            if (t == WINDOW - 2) check("rate_not_yet_valid", int'(rate_valid), 0);
        end
        check("rate_valid_after_terminal", int'(rate_valid), 1);
        check("rate_count_5", int'(rate_out), 5);
        step(1'b0);
        check("rate_valid_drops", int'(rate_valid), 0);

        // Spike on the terminal cycle counts in the ending window only.
        do_reset();
        for (int t = 0; t < 2 * WINDOW; t++) begin
            step(t == 2 || t == 15 || t == 17);
            if (t == 15) check("terminal_spike_counted", int'(rate_out), 2);
            if (t == 31) check("next_window_from_zero", int'(rate_out), 1);
        end

        // Handshake: two unconsumed windows, then accept.
        do_reset();
        rate_ready = 1'b0;
        for (int t = 0; t < 2 * WINDOW; t++) begin
            step((t < 5 && t % 2 == 0) || (t >= 16 && t <= 28 && t % 2 == 0));
            if (t == 15) begin
                check("hs_first_rate", int'(rate_out), 3);
                check("hs_no_overrun_yet", int'(overrun), 0);
            end
        end
        check("hs_overwrite_rate", int'(rate_out), 7);
        check("hs_overrun_set", int'(overrun), 1);
        check("hs_still_valid", int'(rate_valid), 1);
        rate_ready = 1'b1;
        step(1'b0);
        check("hs_valid_drops", int'(rate_valid), 0);
        check("hs_overrun_sticky", int'(overrun), 1);

        // ISI: edges at 10, 13, 40, then a 300-cycle gap.
        do_reset();
        got_isi.delete();
        got_burst.delete();
        for (int t = 0; t < 345; t++) begin
            step(t == 10 || t == 13 || t == 40 || t == 340);
            if (isi_valid) begin
                got_isi.push_back(int'(isi_out));
                got_burst.push_back(burst);
            end
        end
        check("isi_report_count", got_isi.size(), 3);
        for (int i = 0; i < 3 && i < got_isi.size(); i++) begin
            check($sformatf("isi_seq%0d", i),   got_isi[i],        exp_isi_seq[i]);
            check($sformatf("burst_seq%0d", i), int'(got_burst[i]), int'(exp_burst_seq[i]));
        end

        // ena gating: 20 frozen cycles with spike_in toggling.
        do_reset();
        for (int r = 0; r < 37; r++) begin
            ena = !(r >= 5 && r < 25);
            step(ena ? (r == 1 || r == 27) : logic'(r % 2));
            if (r == 34) check("gate_window_not_done", int'(rate_valid), 0);
            if (r == 35) begin
                check("gate_window_done", int'(rate_valid), 1);
                check("gate_rate_count", int'(rate_out), 2);
            end
        end
        ena = 1'b1;

        // Random traffic against the model, with occasional resets.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(499) == 0);
            ena        = ($urandom_range(9) != 0);
            rate_ready = ($urandom_range(1) == 1);
            step($urandom_range(2) == 0);
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_lif_spike_decoder
